// File: rtl/alu_operand_issue.sv
// alu_operand_issue: serialised issue/writeback stage around a registered 32-bit ALU.
// Reads operands from an internal register file, writes results back, and latches the ALU flag.
`default_nettype none

module alu_operand_issue #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_func,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs,
  input  logic [ADDR_W-1:0] instr_rt,
  input  logic              instr_use_imm,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_inp1,
  output logic [DATA_W-1:0] alu_inp2,
  output logic [3:0]        alu_func,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [1:0]        alu_flag,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal_func,
  output logic [1:0]        flag_reg,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;
  localparam logic [1:0] S_FLAG   = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] rf [NREG];
  logic              func_legal;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  // alu_func is held from accept until the next accept, so it still names the op in RESULT/FLAG
  assign func_legal  = (alu_func >= 4'd1) && (alu_func <= 4'd9);
  assign instr_ready = (state == S_IDLE);
  assign rs_val      = (instr_rs == '0) ? '0 : rf[instr_rs];
  assign rt_val      = (instr_rt == '0) ? '0 : rf[instr_rt];
  assign dbg_data    = (dbg_addr == '0) ? '0 : rf[dbg_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      rd_q         <= '0;
      alu_inp1     <= '0;
      alu_inp2     <= '0;
      alu_func     <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      illegal_func <= 1'b0;
      flag_reg     <= 2'b00;
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      wb_valid     <= 1'b0;
      illegal_func <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            alu_inp1 <= rs_val;
            alu_inp2 <= instr_use_imm ? instr_imm : rt_val;
            alu_func <= instr_func;
            rd_q     <= instr_rd;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_RESULT;
        end
        S_RESULT: begin
          if (func_legal) begin
            if (rd_q != '0) begin
              rf[rd_q] <= alu_out;
            end
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= alu_out;
          end else begin
            illegal_func <= 1'b1;
          end
          state <= S_FLAG;
        end
        S_FLAG: begin
          // alu_flag trails alu_out by one cycle, so it becomes valid here
          if (func_legal) begin
            flag_reg <= alu_flag;
          end
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
